id_issue_ctrl: RTL and testbench

//  Issue controller between the I-type/R-type decoders and EX. Holds one registered issue slot,

---
 rtl/id_issue_ctrl_pkg.sv | 25 ++
 rtl/id_issue_ctrl_if.sv | 42 ++++
 rtl/id_issue_ctrl_scoreboard.sv | 87 ++++++++
 rtl/id_issue_ctrl.sv | 93 +++++++++
 tb/tb_id_issue_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/id_issue_ctrl_pkg.sv
// Shared decode/issue types for the id_issue_ctrl slice.
// Optional feature macro: CPU_LOAD_BYPASS_EN (see id_load_scoreboard).
package cpu_defs;

    typedef logic       Bit_t;
    typedef logic [4:0] RegAddr_t;

    typedef enum logic [3:0] {
        OP_INVALID = 4'd0,
        OP_ADDU    = 4'd1,
        OP_SUBU    = 4'd2,
        OP_AND     = 4'd3,
        OP_OR      = 4'd4,
        OP_ORI     = 4'd5,
        OP_ADDIU   = 4'd6,
        OP_LW      = 4'd7,
        OP_SW      = 4'd8
    } Oper_t;

    typedef enum logic {
        ISS_RUN   = 1'b0,
        ISS_DRAIN = 1'b1
    } IssueState_t;

endpackage

// File: rtl/id_issue_ctrl_if.sv
// Decode -> issue -> EX handshake plus load write-back bus.
// Optional feature macro: CPU_LOAD_BYPASS_EN (no effect on this interface).
interface id_issue_if #(
    parameter int CNT_W = 2
);
    import cpu_defs::*;

    Bit_t             id_valid;
    Bit_t             id_ready;
    Oper_t            id_op;
    RegAddr_t         id_raddr1;
    RegAddr_t         id_raddr2;
    RegAddr_t         id_waddr;
    Bit_t             id_we;
    Bit_t             issue_valid;
    Bit_t             ex_ready;
    Oper_t            issue_op;
    RegAddr_t         issue_raddr1;
    RegAddr_t         issue_raddr2;
    RegAddr_t         issue_waddr;
    Bit_t             issue_we;
    Bit_t             wb_valid;
    RegAddr_t         wb_addr;
    Bit_t             flush;
    logic [CNT_W-1:0] load_cnt;
    Bit_t             sb_err;

    modport slave (
        input  id_valid, id_op, id_raddr1, id_raddr2, id_waddr, id_we,
        input  ex_ready, wb_valid, wb_addr, flush,
        output id_ready, issue_valid, issue_op, issue_raddr1,
        output issue_raddr2, issue_waddr, issue_we, load_cnt, sb_err
    );

    modport master (
        output id_valid, id_op, id_raddr1, id_raddr2, id_waddr, id_we,
        output ex_ready, wb_valid, wb_addr, flush,
        input  id_ready, issue_valid, issue_op, issue_raddr1,
        input  issue_raddr2, issue_waddr, issue_we, load_cnt, sb_err
    );

endinterface

// File: rtl/id_issue_ctrl_scoreboard.sv
// Per-GPR outstanding-load scoreboard and hazard lookup.
// Macro CPU_LOAD_BYPASS_EN: loads retiring this cycle no longer cause hazards.
module id_load_scoreboard
    import cpu_defs::*;
#(
    parameter int MAX_LOADS = 2,
    parameter int CNT_W     = $clog2(MAX_LOADS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  Bit_t             id_valid_i,
    input  Oper_t            id_op_i,
    input  RegAddr_t         id_raddr1_i,
    input  RegAddr_t         id_raddr2_i,
    input  RegAddr_t         id_waddr_i,
    input  Bit_t             id_we_i,
    input  Bit_t             load_acc_i,
    input  Bit_t             wb_valid_i,
    input  RegAddr_t         wb_addr_i,
    output Bit_t             hazard_o,
    output logic [CNT_W-1:0] load_cnt_o,
    output logic [CNT_W-1:0] load_cnt_d_o,
    output Bit_t             sb_err_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LOADS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [31:0]      pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    Bit_t             err_q;

    logic [31:0] ret_mask, ret_clr, set_mask, pend_eff;
    Bit_t        ret_hit, ret_zero, ret_dec, ret_err, cnt_full;

    // Retire/allocate bookkeeping and hazard lookup
    always_comb begin
        ret_mask = '0;
        if (wb_valid_i) ret_mask[wb_addr_i] = 1'b1;
        ret_hit  = wb_valid_i & (wb_addr_i != '0) & pend_q[wb_addr_i];
        ret_zero = wb_valid_i & (wb_addr_i == '0) & (cnt_q != '0);
        ret_dec  = (ret_hit | ret_zero) & (cnt_q != '0);
        ret_err  = wb_valid_i & ~ret_dec;
        ret_clr  = ret_hit ? ret_mask : 32'b0;

        set_mask = '0;
        if (load_acc_i && id_waddr_i != '0) set_mask[id_waddr_i] = 1'b1;
        // A same-cycle set beats the clear of the retiring load
        pend_d = (pend_q & ~ret_clr) | set_mask;

        cnt_d = cnt_q;
        if (load_acc_i && !ret_dec)      cnt_d = cnt_q + CNT_ONE;
        else if (!load_acc_i && ret_dec) cnt_d = cnt_q - CNT_ONE;

`ifdef CPU_LOAD_BYPASS_EN
        pend_eff = pend_q & ~ret_mask;
        cnt_full = (cnt_q == CNT_MAX) & ~ret_dec;
`else
        pend_eff = pend_q;
        cnt_full = (cnt_q == CNT_MAX);
`endif

        hazard_o = id_valid_i & (
              ((id_raddr1_i != '0) & pend_eff[id_raddr1_i])
            | ((id_raddr2_i != '0) & pend_eff[id_raddr2_i])
            | (id_we_i & (id_waddr_i != '0) & pend_eff[id_waddr_i])
            | ((id_op_i == OP_LW) & cnt_full));
    end

    // Scoreboard state and sticky error
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            if (ret_err) err_q <= 1'b1;
        end
    end

    assign load_cnt_o   = cnt_q;
    assign load_cnt_d_o = cnt_d;
    assign sb_err_o     = err_q;

endmodule

// File: rtl/id_issue_ctrl.sv
// Issue controller: one registered issue slot plus flush-drain FSM.
// Macro CPU_LOAD_BYPASS_EN enables same-cycle issue past retiring loads.
module id_issue_ctrl
    import cpu_defs::*;
#(
    parameter  int MAX_LOADS = 2,
    localparam int CNT_W     = $clog2(MAX_LOADS + 1)
) (
    input logic  clk,
    input logic  rst_n,
    id_issue_if.slave bus
);

    IssueState_t state_q;
    Bit_t        valid_q;
    Oper_t       op_q;
    RegAddr_t    ra1_q, ra2_q, wa_q;
    Bit_t        we_q;

    Bit_t             hazard, ready, accept, load_acc, sb_err;
    logic [CNT_W-1:0] cnt, cnt_d;

    // Handshake: accept only in RUN with a free or draining slot
    always_comb begin
        ready = rst_n & (state_q == ISS_RUN) & ~bus.flush & ~hazard
              & (~valid_q | bus.ex_ready);
        accept   = bus.id_valid & ready;
        load_acc = accept & (bus.id_op == OP_LW);
    end

    id_load_scoreboard #(
        .MAX_LOADS (MAX_LOADS),
        .CNT_W     (CNT_W)
    ) u_sb (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid_i   (bus.id_valid),
        .id_op_i      (bus.id_op),
        .id_raddr1_i  (bus.id_raddr1),
        .id_raddr2_i  (bus.id_raddr2),
        .id_waddr_i   (bus.id_waddr),
        .id_we_i      (bus.id_we),
        .load_acc_i   (load_acc),
        .wb_valid_i   (bus.wb_valid),
        .wb_addr_i    (bus.wb_addr),
        .hazard_o     (hazard),
        .load_cnt_o   (cnt),
        .load_cnt_d_o (cnt_d),
        .sb_err_o     (sb_err)
    );

    // Drain FSM and issue slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ISS_RUN;
            valid_q <= 1'b0;
            op_q    <= OP_INVALID;
            ra1_q   <= '0;
            ra2_q   <= '0;
            wa_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            unique case (state_q)
                ISS_RUN:   if (bus.flush && cnt_d != '0) state_q <= ISS_DRAIN;
                ISS_DRAIN: if (cnt_d == '0) state_q <= ISS_RUN;
                default:   state_q <= ISS_RUN;
            endcase
            if (bus.flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                op_q    <= bus.id_op;
                ra1_q   <= bus.id_raddr1;
                ra2_q   <= bus.id_raddr2;
                wa_q    <= bus.id_waddr;
                we_q    <= bus.id_we;
            end else if (bus.ex_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.id_ready     = ready;
    assign bus.issue_valid  = valid_q;
    assign bus.issue_op     = op_q;
    assign bus.issue_raddr1 = ra1_q;
    assign bus.issue_raddr2 = ra2_q;
    assign bus.issue_waddr  = wa_q;
    assign bus.issue_we     = we_q;
    assign bus.load_cnt     = cnt;
    assign bus.sb_err       = sb_err;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Directed bench for id_issue_ctrl (MAX_LOADS=2).
// Expectations follow CPU_LOAD_BYPASS_EN when it is defined.
module tb_id_issue_ctrl;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    id_issue_if #(.CNT_W(2)) bus ();

    id_issue_ctrl #(.MAX_LOADS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input Oper_t op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] wa,
                         input logic we);
        bus.id_valid  = v;
        bus.id_op     = op;
        bus.id_raddr1 = r1;
        bus.id_raddr2 = r2;
        bus.id_waddr  = wa;
        bus.id_we     = we;
    endtask

    task automatic wb(input logic v, input logic [4:0] a);
        bus.wb_valid = v;
        bus.wb_addr  = a;
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.ex_ready = 1'b1;
        bus.flush    = 1'b0;
        wb(1'b0, 5'd0);
        drive(1'b1, OP_ADDU, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        tick();
        #1;
        chk("rst_ready", 32'(bus.id_ready), 32'd0);
        chk("rst_valid", 32'(bus.issue_valid), 32'd0);
        chk("rst_cnt", 32'(bus.load_cnt), 32'd0);
        chk("rst_err", 32'(bus.sb_err), 32'd0);
        chk("rst_op", 32'(bus.issue_op), 32'(OP_INVALID));
        chk("rst_wa", 32'(bus.issue_waddr), 32'd0);
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: lw $3 then dependent addu $4,$3
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd3, 1'b1);
        #1 chk("t1_lw_ready", 32'(bus.id_ready), 32'd1);
        tick();
        chk("t1_lw_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_lw_wa", 32'(bus.issue_waddr), 32'd3);
        chk("t1_cnt1", 32'(bus.load_cnt), 32'd1);
        drive(1'b1, OP_ADDU, 5'd3, 5'd0, 5'd4, 1'b1);
        #1 chk("t1_raw_stall", 32'(bus.id_ready), 32'd0);
        tick();
        chk("t1_slot_drained", 32'(bus.issue_valid), 32'd0);
        chk("t1_raw_stall2", 32'(bus.id_ready), 32'd0);
        wb(1'b1, 5'd3);
`ifdef CPU_LOAD_BYPASS_EN
        #1 chk("t1_bypass_ready", 32'(bus.id_ready), 32'd1);
        tick();
        wb(1'b0, 5'd0);
`else
        #1 chk("t1_wb_ready", 32'(bus.id_ready), 32'd0);
        tick();
        wb(1'b0, 5'd0);
        #1 chk("t1_after_ready", 32'(bus.id_ready), 32'd1);
        tick();
`endif
        chk("t1_addu_wa", 32'(bus.issue_waddr), 32'd4);
        chk("t1_addu_op", 32'(bus.issue_op), 32'(OP_ADDU));
        chk("t1_cnt0", 32'(bus.load_cnt), 32'd0);
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // 2: load limit
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd5, 1'b1);
        tick();
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd6, 1'b1);
        tick();
        chk("t2_cnt2", 32'(bus.load_cnt), 32'd2);
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd7, 1'b1);
        #1 chk("t2_full_stall", 32'(bus.id_ready), 32'd0);
        tick();
        chk("t2_cnt_hold", 32'(bus.load_cnt), 32'd2);
        chk("t2_slot_wa", 32'(bus.issue_waddr), 32'd6);
        wb(1'b1, 5'd5);
`ifdef CPU_LOAD_BYPASS_EN
        #1 chk("t2_bypass_ready", 32'(bus.id_ready), 32'd1);
        tick();
        wb(1'b0, 5'd0);
`else
        #1 chk("t2_wb_ready", 32'(bus.id_ready), 32'd0);
        tick();
        wb(1'b0, 5'd0);
        chk("t2_cnt1", 32'(bus.load_cnt), 32'd1);
        #1 chk("t2_ready", 32'(bus.id_ready), 32'd1);
        tick();
`endif
        chk("t2_third_wa", 32'(bus.issue_waddr), 32'd7);
        chk("t2_cnt_back2", 32'(bus.load_cnt), 32'd2);
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        wb(1'b1, 5'd6);
        tick();
        wb(1'b1, 5'd7);
        tick();
        wb(1'b0, 5'd0);
        chk("t2_cnt_empty", 32'(bus.load_cnt), 32'd0);
        chk("t2_no_err", 32'(bus.sb_err), 32'd0);

        // 3: EX back-pressure
        bus.ex_ready = 1'b0;
        drive(1'b1, OP_ORI, 5'd1, 5'd0, 5'd10, 1'b1);
        tick();
        chk("t3_ori_valid", 32'(bus.issue_valid), 32'd1);
        drive(1'b1, OP_ADDU, 5'd2, 5'd0, 5'd11, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t3_bp_ready", 32'(bus.id_ready), 32'd0);
            tick();
            chk("t3_hold_op", 32'(bus.issue_op), 32'(OP_ORI));
            chk("t3_hold_wa", 32'(bus.issue_waddr), 32'd10);
        end
        bus.ex_ready = 1'b1;
        #1 chk("t3_release_ready", 32'(bus.id_ready), 32'd1);
        tick();
        chk("t3_next_wa", 32'(bus.issue_waddr), 32'd11);
        chk("t3_next_op", 32'(bus.issue_op), 32'(OP_ADDU));
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // 4: flush with a load in flight
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd8, 1'b1);
        tick();
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("t4_flush_valid", 32'(bus.issue_valid), 32'd0);
        chk("t4_drain", 32'(dut.state_q), 32'(ISS_DRAIN));
        drive(1'b1, OP_ADDU, 5'd1, 5'd0, 5'd2, 1'b1);
        #1 chk("t4_drain_ready", 32'(bus.id_ready), 32'd0);
        tick();
        chk("t4_drain_hold", 32'(bus.issue_valid), 32'd0);
        wb(1'b1, 5'd8);
        tick();
        wb(1'b0, 5'd0);
        chk("t4_run", 32'(dut.state_q), 32'(ISS_RUN));
        chk("t4_cnt0", 32'(bus.load_cnt), 32'd0);
        #1 chk("t4_run_ready", 32'(bus.id_ready), 32'd1);
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // 5: load accept in the same cycle as a retire
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd9, 1'b1);
        tick();
`ifdef CPU_LOAD_BYPASS_EN
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd9, 1'b1);
`else
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd13, 1'b1);
`endif
        wb(1'b1, 5'd9);
        #1 chk("t5_ready", 32'(bus.id_ready), 32'd1);
        tick();
        wb(1'b0, 5'd0);
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("t5_cnt_same", 32'(bus.load_cnt), 32'd1);
        chk("t5_pend_new", 32'(dut.u_sb.pend_q[bus.issue_waddr]), 32'd1);
`ifndef CPU_LOAD_BYPASS_EN
        chk("t5_pend9_clr", 32'(dut.u_sb.pend_q[9]), 32'd0);
`endif
        wb(1'b1, bus.issue_waddr);
        tick();
        wb(1'b0, 5'd0);
        chk("t5_cnt0", 32'(bus.load_cnt), 32'd0);

        // Load to $0: counted with no pending bit
        drive(1'b1, OP_LW, 5'd1, 5'd0, 5'd0, 1'b1);
        tick();
        drive(1'b0, OP_INVALID, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("z_cnt1", 32'(bus.load_cnt), 32'd1);
        chk("z_pend", 32'(dut.u_sb.pend_q), 32'd0);
        wb(1'b1, 5'd0);
        tick();
        wb(1'b0, 5'd0);
        chk("z_cnt0", 32'(bus.load_cnt), 32'd0);
        chk("z_no_err", 32'(bus.sb_err), 32'd0);

        // 6: spurious write-back
        wb(1'b1, 5'd12);
        tick();
        wb(1'b0, 5'd0);
        chk("t6_err", 32'(bus.sb_err), 32'd1);
        chk("t6_cnt", 32'(bus.load_cnt), 32'd0);
        tick();
        chk("t6_sticky", 32'(bus.sb_err), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_clr", 32'(bus.sb_err), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
